lut3_settle_seq: RTL
====================

Name: lut3_settle_seq

Overview:
- Parametrised, reconfigurable successor to the fixed 3-input truth-table gates in the gate-library netlists.
- Evaluates an NUM_IN-input Boolean function held in a runtime-loadable truth-table register.
- Drives the result through a settling filter: out changes only after the new value persists SETTLE_CYCLES cycles, modelling gate propagation and filtering glitches.
- New tables load serially over a valid/ready handshake and commit atomically.

Parameters:
- NUM_IN, 3: number of logic inputs; truth table width is TBL_W = 2**NUM_IN.
- SETTLE_CYCLES, 4: consecutive differing cycles required before out changes; legal range 1..255.
- INIT_TABLE, 8'h8E: reset truth table. Bit i = output for in_bits == i. The default gives 000→0, 001→1, 010→1, 011→1, 100→0, 101→0, 110→0, 111→1.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_bits  input  NUM_IN  logic inputs. MSB = first-named input (in1); index = {in1,in2,in3}.
- cfg_valid  input  1  config beat valid.
- cfg_ready  output  1  config beat accepted when cfg_valid && cfg_ready.
- cfg_bit  input  1  table bit. Beat k carries table bit k, index 0 first.
- cfg_last  input  1  marks final beat of a load.
- cfg_done  output  1  one-cycle pulse: new table committed.
- cfg_err  output  1  one-cycle pulse: malformed load discarded.
- table_q  output  TBL_W  active truth table, for readback.
- out  output  1  settled function output.
- out_changed  output  1  one-cycle pulse on the edge where out toggles.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - table_q = INIT_TABLE; in_q = 0; out = INIT_TABLE[0]; settle count = 0.
  - Config FSM = IDLE, shadow register = 0, bit counter = 0.
  - cfg_ready = 1; cfg_done = cfg_err = out_changed = 0.
- Input path:
  - in_q <= in_bits every edge.
  - eval = table_q[in_q], combinational from registered state.
- Settling filter:
  - eval == out: settle count <= 0.
  - eval != out, count < SETTLE_CYCLES-1: count <= count+1.
  - eval != out, count == SETTLE_CYCLES-1: out <= eval, count <= 0, out_changed = 1 the following cycle.
  - Result: out changes SETTLE_CYCLES edges after in_q captures the new pattern, i.e. SETTLE_CYCLES+1 edges after in_bits is applied.
  - A return to agreement before the threshold clears the count; the glitch is suppressed.
- Config FSM states: IDLE, LOAD, COMMIT.
  - IDLE/LOAD, cfg_ready = 1. An accepted beat shifts cfg_bit into shadow position (bit counter) and increments the counter; IDLE→LOAD on the first beat.
  - Accepted beat with counter == TBL_W-1 and cfg_last = 1 → COMMIT.
  - cfg_last = 1 on any earlier beat, or cfg_last = 0 on beat TBL_W-1 → cfg_err pulse; shadow and counter cleared; → IDLE. table_q is untouched.
  - COMMIT (1 cycle), cfg_ready = 0: table_q <= shadow, settle count <= 0, cfg_done pulse, counter cleared → IDLE.
  - out is not forced on commit; it re-settles through the filter against the new table.
  - During LOAD, evaluation continues with the old table_q. No partial table is ever visible.
  - cfg_valid low mid-load: the FSM waits in LOAD indefinitely, with no timeout.
- Reset asserted mid-load or mid-settle discards all progress and restores the reset values immediately.
- Counter widths: bit counter NUM_IN+1 bits; settle count 8 bits.

Test Plan:
- Reset, then sweep in_bits 0..7, holding each 10 cycles (defaults) → out follows 0,1,1,1,0,0,0,1. Each change appears 5 edges after in_bits is applied, with exactly one out_changed pulse.
- out=0, in_bits=000; apply 001 for 2 cycles, then back to 000 → out stays 0, no out_changed (glitch filtered). Hold 001 for 5 cycles → out=1.
- Load 8 beats LSB-first encoding 8'h01, cfg_last on beat 8, with in_bits=111 held (out=1) → cfg_done 1 cycle after beat 8, table_q=8'h01, cfg_ready low exactly 1 cycle, out falls to 0 four edges after commit.
- Load 5 beats with cfg_last on beat 5 → cfg_err pulse, table_q stays 8'h8E, a next full load succeeds.
- Load 8 beats with cfg_valid toggling 1-0-1 and cfg_last=0 on beat 8 → cfg_err; toggle during a good load → correct commit.
- Assert rst_n=0 asynchronously after beat 4 of a load and mid-settle → table_q=8'h8E, out=0, counters 0 without waiting for a clock edge. Rerun with NUM_IN=4, SETTLE_CYCLES=1 → 16-beat load, single-cycle settle.

Source files
------------

// File: rtl/lut3_settle_seq.sv
// rtl/lut3_settle_seq.sv - runtime-loadable truth-table gate with settling output filter
module lut3_settle_seq #(
  parameter int                      NUM_IN        = 3,
  parameter int                      SETTLE_CYCLES = 4,
  parameter logic [(2**NUM_IN)-1:0]  INIT_TABLE    = 8'h8E
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_IN-1:0]          in_bits,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic                       cfg_bit,
  input  logic                       cfg_last,
  output logic                       cfg_done,
  output logic                       cfg_err,
  output logic [(2**NUM_IN)-1:0]     table_q,
  output logic                       out,
  output logic                       out_changed
);

  localparam int              TBL_W      = 2**NUM_IN;
  localparam int              CW         = NUM_IN + 1;
  localparam logic [7:0]      SETTLE_MAX = 8'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0]   LAST_IDX   = CW'(TBL_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} cfg_state_t;

  cfg_state_t         state, state_nxt;
  logic [NUM_IN-1:0]  in_q;
  logic [7:0]         settle_cnt;
  logic [TBL_W-1:0]   shadow;
  logic [CW-1:0]      bit_cnt;
  logic               accept;
  logic               at_last_idx;
  logic               beat_bad;
  logic               beat_commit;
  logic               eval;

  assign accept      = cfg_valid && cfg_ready;
  assign at_last_idx = (bit_cnt == LAST_IDX);
  // A beat is malformed when cfg_last disagrees with whether it is the final table bit.
  assign beat_bad    = accept && (cfg_last != at_last_idx);
  assign beat_commit = accept && cfg_last && at_last_idx;
  assign eval        = table_q[in_q];

  // Config FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Config FSM next-state: collect beats, commit on a well-formed last beat, abort on a bad one.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, LOAD: begin
        if (beat_commit)   state_nxt = COMMIT;
        else if (beat_bad) state_nxt = IDLE;
        else if (accept)   state_nxt = LOAD;
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Config FSM outputs: beats are refused only during the single commit cycle.
  always_comb begin
    cfg_ready = 1'b1;
    if (state == COMMIT) cfg_ready = 1'b0;
  end

  // Shadow table assembly and atomic commit into the active table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      table_q  <= INIT_TABLE;
      shadow   <= '0;
      bit_cnt  <= '0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      if (state == COMMIT) begin
        table_q  <= shadow;
        bit_cnt  <= '0;
        cfg_done <= 1'b1;
      end else if (beat_bad) begin
        shadow   <= '0;
        bit_cnt  <= '0;
        cfg_err  <= 1'b1;
      end else if (accept) begin
        shadow[bit_cnt[NUM_IN-1:0]] <= cfg_bit;
        bit_cnt                     <= bit_cnt + 1'b1;
      end
    end
  end

  // Input capture and settling filter; a commit restarts settling against the new table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q        <= '0;
      settle_cnt  <= '0;
      out         <= INIT_TABLE[0];
      out_changed <= 1'b0;
    end else begin
      in_q        <= in_bits;
      out_changed <= 1'b0;
      if (state == COMMIT) begin
        settle_cnt <= '0;
      end else if (eval == out) begin
        settle_cnt <= '0;
      end else if (settle_cnt == SETTLE_MAX) begin
        out         <= eval;
        settle_cnt  <= '0;
        out_changed <= 1'b1;
      end else begin
        settle_cnt <= settle_cnt + 8'd1;
      end
    end
  end

endmodule
